factorial_bcd: RTL and testbench



---
 rtl/factorial_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/factorial_bcd.sv | 133 +++++++++++++
 tb/tb_factorial_bcd.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
//==============================================================================
// factorial_pkg
// Widths and state encoding shared by the factorial engine and its BCD stage.
// Revision: 1.0
//==============================================================================
`default_nettype none

package factorial_pkg;

    localparam int FACT_RESULT_W = 46;
    localparam int DATA_W        = FACT_RESULT_W;
    localparam int DIGITS        = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
//==============================================================================
// bcd_digit_adj
// Double-dabble correction cell: adds 3 to a BCD digit when it is 5 or more.
// Revision: 1.0
//==============================================================================
`default_nettype none

module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Digits never exceed 9 here, so the 4-bit sum cannot wrap.
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/factorial_bcd.sv
//==============================================================================
// factorial_bcd
// Sequential binary-to-BCD converter with a one-entry holding register.
// Revision: 1.0
//==============================================================================
`default_nettype none

module factorial_bcd #(
    parameter int DATA_W = factorial_pkg::DATA_W,
    parameter int DIGITS = factorial_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [3:0]            out_digits,
    output logic                  out_valid,
    output logic                  out_busy,
    output logic                  out_overflow
);

    import factorial_pkg::*;

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W);

    bcd_state_t              r_state;
    logic [DATA_W-1:0]       r_bin;
    logic [BCD_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_pend;
    logic                    r_pend_full;
    logic [BCD_W-1:0]        r_out_bcd;
    logic [3:0]              r_out_digits;
    logic                    r_out_valid;
    logic                    r_overflow;

    logic [BCD_W-1:0]        w_adj;
    logic [BCD_W+DATA_W-1:0] w_shift;
    logic [3:0]              w_digits;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_bcd[4*gi +: 4]),
                .o_digit (w_adj[4*gi +: 4])
            );
        end
    endgenerate

    // The MSB shifted out of the accumulator is always zero for in-range inputs.
    assign w_shift = {w_adj, r_bin} << 1;

    always_comb begin
        w_digits = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_digits = 4'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_out_bcd    <= '0;
            r_out_digits <= 4'd0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pend_full || in_valid) begin
                        // A queued value has priority; a simultaneous input refills the slot.
                        if (r_pend_full) begin
                            r_bin       <= r_pend;
                            r_pend_full <= in_valid;
                            if (in_valid) begin
                                r_pend <= in_data;
                            end
                        end else begin
                            r_bin <= in_data;
                        end
                        r_bcd   <= '0;
                        r_cnt   <= CNT_W'(DATA_W - 1);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= w_shift;
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_out_bcd    <= r_bcd;
                    r_out_digits <= w_digits;
                    r_out_valid  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if ((r_state != IDLE) && in_valid) begin
                if (!r_pend_full) begin
                    r_pend      <= in_data;
                    r_pend_full <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign out_bcd      = r_out_bcd;
    assign out_digits   = r_out_digits;
    assign out_valid    = r_out_valid;
    assign out_busy     = (r_state != IDLE);
    assign out_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_factorial_bcd.sv
//==============================================================================
// tb_factorial_bcd
// Scoreboard bench for factorial_bcd.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_factorial_bcd;

    import factorial_pkg::*;

    localparam int BW = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [BW-1:0]     out_bcd;
    logic [3:0]        out_digits;
    logic              out_valid;
    logic              out_busy;
    logic              out_overflow;

    typedef struct packed {
        logic [BW-1:0] bcd;
        logic [3:0]    dig;
    } exp_t;

    exp_t sb[$];
    int   pulse_cyc[$];
    int   cyc    = 0;
    int   pulses = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    factorial_bcd #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_bcd      (out_bcd),
        .out_digits   (out_digits),
        .out_valid    (out_valid),
        .out_busy     (out_busy),
        .out_overflow (out_overflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every out_valid pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (out_valid) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: out_valid with out_bcd=%h, none expected", out_bcd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (out_bcd !== e.bcd) begin
                    errors++;
                    $display("FAIL sb_bcd: got %h expected %h", out_bcd, e.bcd);
                end
                checks++;
                if (out_digits !== e.dig) begin
                    errors++;
                    $display("FAIL sb_digits: got %0d expected %0d", out_digits, e.dig);
                end
            end
        end
    end

    function automatic exp_t model(input logic [DATA_W-1:0] v);
        exp_t e;
        longint unsigned x;
        x     = 64'(v);
        e.bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.dig = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (e.bcd[4*i +: 4] != 4'd0) e.dig = 4'(i + 1);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic start(input logic [DATA_W-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();
        checks++;
        if (out_bcd !== '0) begin errors++; $display("FAIL rst_bcd: got %h expected 0", out_bcd); end
        checks++;
        if (out_digits !== 4'd0) begin errors++; $display("FAIL rst_digits: got %0d expected 0", out_digits); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", out_busy); end
        checks++;
        if (out_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", out_overflow); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single(input logic [DATA_W-1:0] v, input logic [BW-1:0] eb, input logic [3:0] ed);
        int n;
        bit seen;
        exp_t e;
        e.bcd = eb;
        e.dig = ed;
        sb.push_back(e);
        start(v);
        n    = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            step();
            n++;
            if (n == 1) begin
                checks++;
                if (out_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", out_busy); end
            end
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 48) begin
            errors++;
            $display("FAIL single_latency: value %0d got %0d cycles (seen=%b) expected 48", v, n, seen);
        end
        checks++;
        if (out_busy !== 1'b0) begin errors++; $display("FAIL single_busy_pulse: got %b expected 0", out_busy); end
        checks++;
        if (out_overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b expected 0", out_overflow); end
        step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL single_drain: %0d results outstanding expected 0", sb.size()); end
    endtask

    task automatic test_vectors();
        test_single(46'd1307674368000, 56'h01307674368000, 4'd13);
        test_single(46'd0, 56'h0, 4'd1);
        test_single(46'd120, 56'h120, 4'd3);
        test_single({46{1'b1}}, 56'h70368744177663, 4'd14);
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [DATA_W-1:0] v;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            r = {$urandom, $urandom};
            v = r[DATA_W-1:0] >> $urandom_range(0, 40);
            e = model(v);
            test_single(v, e.bcd, e.dig);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int t = 0; t <= 20; t++) begin
            if (t == 0) start(46'd5040);
            if (t == 5) start(46'd40320);
            if (t == 8) start(46'd362880);
            if (t == 15) begin
                checks++;
                if (out_overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf_set: got %b expected 1", out_overflow); end
            end
            if (t == 20) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        checks++;
        if (out_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", out_busy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", out_overflow); end
        p0 = pulses;
        repeat (120) step();
        checks++;
        if (pulses != p0) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses expected 0", pulses - p0); end
        test_single(46'd6, 56'h6, 4'd1);
    endtask

    task automatic test_pulse_cycle();
        int t0, p0, psz;
        exp_t e;
        e = model(46'd3628800);   sb.push_back(e);
        e = model(46'd39916800);  sb.push_back(e);
        e = model(46'd479001600); sb.push_back(e);
        t0  = cyc;
        p0  = pulses;
        psz = pulse_cyc.size();
        for (int t = 0; t < 300 && pulses < p0 + 3; t++) begin
            if (t == 0) start(46'd3628800);
            if (t == 5) start(46'd39916800);
            if (t == 48) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL pc_pulse48: got %b expected 1", out_valid); end
                start(46'd479001600);
            end
            step();
        end
        step();
        checks++;
        if (pulse_cyc.size() < psz + 3) begin
            errors++;
            $display("FAIL pc_count: got %0d pulses expected 3", pulse_cyc.size() - psz);
        end else if (pulse_cyc[psz] != t0 + 48 || pulse_cyc[psz+1] != t0 + 96 || pulse_cyc[psz+2] != t0 + 144) begin
            errors++;
            $display("FAIL pc_timing: got %0d,%0d,%0d expected 48,96,144", pulse_cyc[psz] - t0,
                     pulse_cyc[psz+1] - t0, pulse_cyc[psz+2] - t0);
        end
        checks++;
        if (out_overflow !== 1'b0) begin errors++; $display("FAIL pc_overflow: got %b expected 0", out_overflow); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL pc_drain: %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int t0, p0, psz;
        exp_t e;
        e.bcd = 56'h24;  e.dig = 4'd2; sb.push_back(e);
        e.bcd = 56'h720; e.dig = 4'd3; sb.push_back(e);
        t0  = cyc;
        p0  = pulses;
        psz = pulse_cyc.size();
        for (int t = 0; t < 300 && pulses < p0 + 2; t++) begin
            if (t == 0) start(46'd24);
            if (t == 10) start(46'd720);
            if (t == 19) begin
                checks++;
                if (out_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_early: got %b expected 0", out_overflow); end
            end
            if (t == 20) start(46'd999);
            if (t == 21) begin
                checks++;
                if (out_overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_set: got %b expected 1", out_overflow); end
            end
            step();
        end
        repeat (60) step();
        checks++;
        if (pulse_cyc.size() != psz + 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses expected 2", pulse_cyc.size() - psz);
        end else if (pulse_cyc[psz] != t0 + 48 || pulse_cyc[psz+1] != t0 + 96) begin
            errors++;
            $display("FAIL b2b_timing: got %0d,%0d expected 48,96", pulse_cyc[psz] - t0, pulse_cyc[psz+1] - t0);
        end
        checks++;
        if (out_overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_sticky: got %b expected 1", out_overflow); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d outstanding expected 0", sb.size()); end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_vectors();
        test_random();
        test_reset_mid();
        test_pulse_cycle();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
